hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and memory-wait stalls,
// branch flushes, memory-timeout watchdog and stall/flush performance counters.
module hazard_unit #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 MemTimeout,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    localparam int unsigned          WCNT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0]    WAIT_MAX = WCNT_W'(WAIT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WCNT_W-1:0] wait_cnt;
    logic              lw_stall;
    logic              mem_stall;
    logic              wait_hit;

    // Forward selects: Memory stage wins over Writeback; x0 never forwards
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    // Stall/flush decode; a memory wait freezes the back end and defers flushes
    always_comb begin
        lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_stall = MemReqM && !MemReadyM;
        StallF    = lw_stall || mem_stall;
        StallD    = lw_stall || mem_stall;
        StallE    = mem_stall;
        StallM    = mem_stall;
        FlushD    = PCSrcE && !mem_stall;
        FlushE    = (lw_stall || PCSrcE) && !mem_stall;
    end

    // This edge completes the WAIT_LIMIT-th consecutive waiting cycle
    always_comb begin
        wait_hit = mem_stall && (wait_cnt >= (WAIT_MAX - WCNT_W'(1)));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state; TIMEOUT is sticky until reset
    always_comb begin
        state_n = state;
        case (state)
            RUN: begin
                if (wait_hit) begin
                    state_n = TIMEOUT;
                end else if (mem_stall) begin
                    state_n = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wait_hit) begin
                    state_n = TIMEOUT;
                end else if (!mem_stall) begin
                    state_n = RUN;
                end
            end
            TIMEOUT: state_n = TIMEOUT;
            default: state_n = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        MemTimeout = 1'b0;
        if (state == TIMEOUT) begin
            MemTimeout = 1'b1;
        end
    end

    // Consecutive memory-wait counter, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!mem_stall) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

    // Saturating stall and flush performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
            if (FlushD && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios followed by random traffic.
module tb_hazard_unit;

    localparam int unsigned CW   = 4;
    localparam int unsigned WL   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct {
        int fa; int fb;
        int sf; int sd; int se; int sm;
        int fd; int fe; int to;
        int sc; int fc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: length of current memory-wait run, sticky timeout, counts
    int   run_len = 0;
    int   to_m    = 0;
    int   sc_m    = 0;
    int   fc_m    = 0;

    function automatic int fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs, then advance the reference across the edge
    task automatic step();
        exp_t e;
        int   lw, ms, sf, fd;
        lw = (ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) ? 1 : 0;
        ms = (MemReqM && !MemReadyM) ? 1 : 0;
        sf = (lw || ms) ? 1 : 0;
        fd = (PCSrcE && !ms) ? 1 : 0;
        e.fa = fwd(Rs1E);
        e.fb = fwd(Rs2E);
        e.sf = sf; e.sd = sf; e.se = ms; e.sm = ms;
        e.fd = fd;
        e.fe = ((lw || PCSrcE) && !ms) ? 1 : 0;
        e.to = to_m; e.sc = sc_m; e.fc = fc_m;
        q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            run_len = 0; to_m = 0; sc_m = 0; fc_m = 0;
        end else begin
            run_len = ms ? run_len + 1 : 0;
            if (run_len >= WL) to_m = 1;
            if (sf && sc_m < CMAX) sc_m++;
            if (fd && fc_m < CMAX) fc_m++;
        end
        #2;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Monitor: the unit presents outputs every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ForwardAE",  int'(ForwardAE),  e.fa);
            chk("ForwardBE",  int'(ForwardBE),  e.fb);
            chk("StallF",     int'(StallF),     e.sf);
            chk("StallD",     int'(StallD),     e.sd);
            chk("StallE",     int'(StallE),     e.se);
            chk("StallM",     int'(StallM),     e.sm);
            chk("FlushD",     int'(FlushD),     e.fd);
            chk("FlushE",     int'(FlushE),     e.fe);
            chk("MemTimeout", int'(MemTimeout), e.to);
            chk("StallCount", int'(StallCount), e.sc);
            chk("FlushCount", int'(FlushCount), e.fc);
        end
    end

    initial begin
        int hold;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        step();                       // reset state, comb outputs live in reset
        rst_n = 1'b1;
        step();

        // Forwarding priority and x0 exclusion
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1; Rs2E = 5;
        step();
        RegWriteM = 0;
        step();
        Rs1E = 0; RdM = 0; RegWriteM = 1; Rs2E = 0;
        step();
        idle_inputs();

        // Load-use stall for one cycle
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        step();
        idle_inputs();
        step();

        // Branch held behind a memory wait, flushes once ready
        PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
        repeat (3) step();
        MemReadyM = 1;
        step();
        idle_inputs();
        step();

        // Timeout after WL waiting cycles, sticky, cleared by reset
        MemReqM = 1; MemReadyM = 0;
        repeat (WL + 1) step();
        MemReadyM = 1;
        repeat (2) step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Stall counter saturation
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        repeat (20) step();
        idle_inputs();
        step();

        // Random traffic with occasional long waits and resets
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            PCSrcE      = ($urandom_range(0, 3) == 0);
            if (hold == 0 && $urandom_range(0, 15) == 0) hold = $urandom_range(2, 7);
            if (hold > 0) begin
                MemReqM = 1; MemReadyM = 0; hold--;
            end else begin
                MemReqM = 1'($urandom_range(0, 1)); MemReadyM = ($urandom_range(0, 2) != 0);
            end
            rst_n = ($urandom_range(0, 39) != 0);
            step();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
